picorv_write_buffer: RTL
========================

# picorv_write_buffer

Posted-write buffer between the picorv32 native memory interface and `picorv32_freeahb_adapter`, inside the PicoRV AHB master. Core stores are acknowledged after one cycle and drained to the adapter in order; reads pass through only after ordering rules are met. This takes AHB write latency off the core's store path.

## Interface
Parameters:
- `DEPTH`, 4: buffer entries; power of two, 2..16.

Ports:
- `clk` in 1: the single clock (same clock as the core and adapter).
- `resetn` in 1: reset; asynchronous, active-low.
- `c_valid` in 1: core request valid (`mem_valid`).
- `c_instr` in 1: core request is an instruction fetch.
- `c_addr` in 32: core address.
- `c_wdata` in 32: core write data.
- `c_wstrb` in 4: core byte strobes; 0 means read.
- `c_ready` out 1: single-cycle acknowledge to the core.
- `c_rdata` out 32: read data to the core; valid while `c_ready`=1.
- `m_valid` out 1: request to the adapter.
- `m_instr` out 1: fetch flag to the adapter.
- `m_addr` out 32: address to the adapter.
- `m_wdata` out 32: write data to the adapter.
- `m_wstrb` out 4: strobes to the adapter; 0 means read.
- `m_ready` in 1: single-cycle completion from the adapter.
- `m_rdata` in 32: adapter read data; sampled when `m_ready`=1.
- `wb_empty` out 1: buffer holds no entries.
- `wb_full` out 1: buffer level equals `DEPTH`.
- `wb_level` out clog2(DEPTH)+1: current entry count.

## Operation
**FIFO**
- Entries are {addr, wdata, wstrb}.
- Read and write pointers are clog2(DEPTH) bits and wrap modulo `DEPTH`.
- Level counter runs 0..DEPTH.

**Write acceptance**
- Accepted when `c_valid` & |`c_wstrb` & ~`c_ready` & `wb_level`<DEPTH, evaluated before the clock edge.
- At that edge: push the entry, and `c_ready` goes 1 for exactly one cycle.
- When full, the request stalls with `c_ready`=0.
- A pop in the same cycle does not make room; acceptance happens at the next edge.

**Downstream FSM**
- States: IDLE, WR, RD.
- IDLE → WR when level>0. Load the head entry into `m_*` with `m_valid`=1 and `m_instr`=0.
- WR: on `m_ready`, pop the head and clear `m_valid`, then return to IDLE. No back-to-back issue; there is one idle cycle between transfers.
- IDLE → RD when a read is pending (`c_valid` & `c_wstrb`==0 & ~`c_ready`) and level==0.
  - Load `c_addr` and `c_instr` into `m_*`, with `m_wstrb`=0 and `m_valid`=1.
- RD: on `m_ready`, capture `m_rdata` into `c_rdata`, assert `c_ready` for one cycle next cycle, clear `m_valid`, return to IDLE.
- In IDLE, draining takes priority over reads unless the macro below allows a fetch to go first.

**Rules**
- All `m_*` outputs are registered and held stable while `m_valid`=1.
- Simultaneous push and pop leaves the level unchanged.
- `c_rdata` holds its last value outside read acknowledges.

## Timing
- Reset values: `c_ready`=0, `c_rdata`=0, `m_valid`=0, `m_instr`=0, `m_addr`=0, `m_wdata`=0, `m_wstrb`=0, `wb_empty`=1, `wb_full`=0, `wb_level`=0.
- Write acknowledge: `c_valid` rises in cycle N, `c_ready`=1 in cycle N+1 (not full).
- Drain: entry pushed at edge N, `m_valid`=1 from cycle N+2 (IDLE in cycle N+1).
- Read acknowledge: `m_ready` in cycle M, `c_ready`=1 in cycle M+1.
- Reset mid-operation: all entries are discarded, and `m_valid` and `c_ready` drop asynchronously. A transfer in flight in the adapter is abandoned.

## Configuration
- `PICORV_WBUF_IFETCH_BYPASS_EN` defined:
  - In IDLE, a pending fetch (`c_instr`=1) issues before draining, even if level>0.
  - Condition: no valid entry matches `c_addr[31:2]`. On a match, the fetch waits for level==0.
  - Data reads always wait for level==0.
- Undefined: all reads wait for level==0. No address comparators are synthesized.

## Test plan
1. Reset check: hold `resetn`=0 → every output equals its reset value; `wb_empty`=1.
2. Write then read of the same address: store 0xDEADBEEF to 0x100 with `c_wstrb`=0xF.
   - `c_ready` is 1 cycle after `c_valid`.
   - `m_valid`/`m_addr`=0x100 two cycles after the push.
   - A load from 0x100 issues only after `m_ready` pops the write.
   - `c_rdata` equals the supplied `m_rdata`.
3. Fill with DEPTH=4 and `m_ready` held 0: 4 writes accepted, `wb_full`=1, `wb_level`=4.
   - 5th write sees `c_ready`=0 until one `m_ready` pulse, then is acked at the following edge+1.
4. Wrap: 10 writes to 0x100..0x124 with `m_ready` every 3rd cycle.
   - Downstream addresses, data and strobes appear in exact order.
   - Final `wb_empty`=1.
5. Macro defined: queue writes to 0x2000 and 0x2004; fetch 0x4000_0000 issues before either drains.
   - Fetch 0x2004 waits until `wb_level`=0.
   - With the macro undefined, both fetches wait for empty.
6. Reset mid-drain: drop `resetn` while `m_valid`=1 and `wb_level`=3.
   - `m_valid`=0 and `wb_level`=0 immediately.
   - After release, no stale transfer issues.

Source files
------------

// File: rtl/picorv_write_buffer.sv
// Posted-write buffer between the picorv32 native port and the AHB adapter; stores ack in one cycle.
// Optional PICORV_WBUF_IFETCH_BYPASS_EN: fetches to words not held in the buffer overtake queued writes.
module picorv_write_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     c_valid,
    input  logic                     c_instr,
    input  logic [31:0]              c_addr,
    input  logic [31:0]              c_wdata,
    input  logic [3:0]               c_wstrb,
    output logic                     c_ready,
    output logic [31:0]              c_rdata,
    output logic                     m_valid,
    output logic                     m_instr,
    output logic [31:0]              m_addr,
    output logic [31:0]              m_wdata,
    output logic [3:0]               m_wstrb,
    input  logic                     m_ready,
    input  logic [31:0]              m_rdata,
    output logic                     wb_empty,
    output logic                     wb_full,
    output logic [$clog2(DEPTH):0]   wb_level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LVL = (PW+1)'(DEPTH);

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } wb_entry_t;

    typedef enum logic [1:0] {IDLE, WR, RD} state_t;

    wb_entry_t     mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   level;
    state_t        state, state_nxt;
    logic          push, pop, rd_pend, issue_wr, issue_rd, fetch_bypass;

    // c_ready gates both paths so an acknowledged request is never taken twice
    assign rd_pend = c_valid && (c_wstrb == 4'b0) && !c_ready;
    assign push    = c_valid && (|c_wstrb) && !c_ready && (level < FULL_LVL);
    assign pop     = (state == WR) && m_ready;

`ifdef PICORV_WBUF_IFETCH_BYPASS_EN
    logic [DEPTH-1:0] hit;
    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        logic [PW-1:0] off;
        assign off    = PW'(i) - rd_ptr;
        assign hit[i] = ({1'b0, off} < level) && (mem[i].addr[31:2] == c_addr[31:2]);
    end
    assign fetch_bypass = rd_pend && c_instr && (hit == '0);
`else
    assign fetch_bypass = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        issue_wr  = 1'b0;
        issue_rd  = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_bypass) begin
                    issue_rd  = 1'b1;
                    state_nxt = RD;
                end else if (level != '0) begin
                    issue_wr  = 1'b1;
                    state_nxt = WR;
                end else if (rd_pend) begin
                    issue_rd  = 1'b1;
                    state_nxt = RD;
                end
            end
            WR:      if (m_ready) state_nxt = IDLE;
            RD:      if (m_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Entry storage carries no reset; pointers and level define what is valid
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{addr: c_addr, wdata: c_wdata, wstrb: c_wstrb};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            c_ready <= 1'b0;
            c_rdata <= '0;
            m_valid <= 1'b0;
            m_instr <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_wstrb <= '0;
        end else begin
            state   <= state_nxt;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            level   <= level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            c_ready <= push || ((state == RD) && m_ready);
            if ((state == RD) && m_ready) c_rdata <= m_rdata;
            if (issue_wr) begin
                m_valid <= 1'b1;
                m_instr <= 1'b0;
                m_addr  <= mem[rd_ptr].addr;
                m_wdata <= mem[rd_ptr].wdata;
                m_wstrb <= mem[rd_ptr].wstrb;
            end else if (issue_rd) begin
                m_valid <= 1'b1;
                m_instr <= c_instr;
                m_addr  <= c_addr;
                m_wdata <= '0;
                m_wstrb <= 4'b0;
            end else if ((state != IDLE) && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    assign wb_empty = (level == '0);
    assign wb_full  = (level == FULL_LVL);
    assign wb_level = level;
endmodule
